// File: rtl/program_sequencer.sv
// Program counter and next-address generator for the 8-bit tiny processor,
// with debug hold / single-step control and a saturating executed-instruction counter.
module program_sequencer #(
  parameter int PC_W   = 8,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp,
  input  logic              jmp_nz,
  input  logic [3:0]        ir_nibble,
  input  logic              dont_jmp,
  input  logic              dbg_hold,
  input  logic              dbg_step,
  output logic [PC_W-1:0]   pm_addr,
  output logic [PC_W-1:0]   pc,
  output logic              held,
  output logic              self_loop,
  output logic [ICNT_W-1:0] icnt
);

  // state | meaning
  // BOOT  | first cycle after reset release, fetches address 0
  // RUN   | free-running instruction flow
  // HOLD  | frozen by debug; dbg_step releases exactly one instruction
  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t            state;
  logic              take;
  logic              advance;
  logic [PC_W-1:0]   tgt;
  logic [PC_W-1:0]   seq_addr;

  // Jump targets stay within the current 16-instruction page.
  assign take     = jmp | (jmp_nz & ~dont_jmp);
  assign tgt      = {pc[PC_W-1:4], ir_nibble};
  assign seq_addr = take ? tgt : pc + PC_W'(1);

  // Release wins over a simultaneous step; either way the cycle executes.
  assign advance  = (state == RUN) || ((state == HOLD) && (dbg_step || !dbg_hold));
  assign held     = (state == HOLD);

  always_comb begin
    pm_addr = '0;
    if (!reset) begin
      if (advance)
        pm_addr = seq_addr;
      else if (state == HOLD)
        pm_addr = pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc        <= '0;
      icnt      <= '0;
      self_loop <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          pc    <= '0;
          state <= dbg_hold ? HOLD : RUN;
        end
        RUN, HOLD: begin
          if (advance) begin
            pc <= seq_addr;
            if (icnt != '1)
              icnt <= icnt + ICNT_W'(1);
            if (take && (tgt == pc))
              self_loop <= 1'b1;
          end
          state <= dbg_hold ? HOLD : RUN;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Program counter and next-address generator for the 8-bit tiny processor.
- Sits directly upstream of the instruction decoder. Its pm_addr drives program memory, whose data becomes the decoder's next_instr.
- Consumes the decoder's jmp, jmp_nz and ir_nibble, plus the ALU zero-flag qualifier dont_jmp.
- Adds a debug hold / single-step controller and an executed-instruction counter.

Parameters:
- PC_W, 8: program-counter and pm_addr width; must be at least 5.
- ICNT_W, 16: width of the executed-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- jmp  input  1  unconditional jump; ir holds a 1110xxxx instruction.
- jmp_nz  input  1  conditional jump; ir holds a 1111xxxx instruction.
- ir_nibble  input  4  low nibble of ir; the jump target offset.
- dont_jmp  input  1  ALU zero flag registered; 1 suppresses jmp_nz.
- dbg_hold  input  1  level request to freeze instruction flow.
- dbg_step  input  1  single-cycle pulse; releases exactly one instruction while held.
- pm_addr  output  PC_W  combinational next fetch address.
- pc  output  PC_W  registered address of the instruction currently in ir.
- held  output  1  1 while the sequencer is frozen.
- self_loop  output  1  registered sticky flag: a taken jump targeted its own address.
- icnt  output  ICNT_W  executed-instruction count, saturating.

Behaviour:
- Reset, asynchronous: pc=0, state=BOOT, held=0, self_loop=0, icnt=0. pm_addr=0 combinationally while reset=1.
- Jump target: tgt = {pc[PC_W-1:4], ir_nibble}. The upper bits come from the current pc; there is no carry into the upper bits.
- Taken jump: take = jmp OR (jmp_nz AND NOT dont_jmp). If jmp and jmp_nz are both asserted, treat it as jmp.
- State BOOT (first cycle after reset release):
  - pm_addr=0; pc<=0.
  - No jump evaluation; icnt unchanged.
  - Next state: HOLD if dbg_hold=1, otherwise RUN.
- State RUN:
  - pm_addr = take ? tgt : pc+1, wrapping modulo 2^PC_W (pc all-ones goes to 0).
  - pc<=pm_addr; icnt<=icnt+1, saturating at all-ones.
  - If take=1 and tgt==pc, set self_loop (it stays set until reset).
  - If dbg_hold=1, next state is HOLD, and this cycle still advances normally. Hold takes effect after the current instruction.
- State HOLD:
  - held=1.
  - With dbg_step=0: pm_addr=pc so the decoder refetches the same instruction; pc and icnt do not change.
  - With dbg_step=1: behave exactly as RUN for one cycle (take/tgt, pc advance, icnt++, self_loop), then stay in HOLD.
  - With dbg_hold=0: next state is RUN. Release has priority over a simultaneous step, and that cycle behaves as RUN.
- held is combinational from state: 1 exactly in HOLD.
- The state encoding is a 2-bit register. The unused encoding must recover to BOOT on the next edge.
- Reset mid-operation: everything returns to reset values immediately, without waiting for a clock edge. The first post-reset fetch address is always 0.
- Jump inputs are ignored in BOOT and in HOLD without a step.

Test Plan:
1. Reset, then release with no jumps for 5 cycles -> pm_addr sequence 0,1,2,3,4,5; pc lags pm_addr by one cycle; icnt=4 after the 5th edge (BOOT does not count).
2. pc=0x37, jmp=1, ir_nibble=0xA -> pm_addr=0x3A and pc=0x3A after the edge. With jmp_nz=1 and dont_jmp=1 -> pm_addr=0x38. With jmp_nz=1 and dont_jmp=0 -> pm_addr=0x3A.
3. pc=0xFF, no jump -> pm_addr=0x00 (wrap). pc=0x25, jmp=1, ir_nibble=0x5 -> self_loop=1, and it stays 1 through later non-jump cycles.
4. RUN at pc=0x10, raise dbg_hold -> pc=0x11, then held=1 and pm_addr=0x11 for 3 cycles with icnt frozen. One dbg_step pulse -> pc=0x12, held stays 1. Drop dbg_hold -> pc advances 0x13, 0x14.
5. Drive icnt to 0xFFFE by forcing it or running long -> after 2 more RUN cycles icnt=0xFFFF, and it stays there. Assert reset asynchronously mid-cycle -> icnt=0, pc=0 and pm_addr=0 before the next clock edge.
6. dbg_hold=1 during reset release -> BOOT fetches 0, then HOLD with pm_addr=0 and no advance until dbg_step or release.
